// File: rtl/hazard_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sched_if
// Purpose  : Hazard/scheduler signal bundle between datapath and controller.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_sched_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             regWriteM, regWriteW, loadE, pcSrcE, mdStartE, cntClr;
    logic [1:0]       fwdAE, fwdBE;
    logic             stallF, stallD, stallE, flushD, flushE, flushM;
    logic             mdBusy, mdDone;
    logic [CNT_W-1:0] stallCnt;

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regWriteM, regWriteW, loadE, pcSrcE, mdStartE, cntClr,
        output fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM,
        output mdBusy, mdDone, stallCnt
    );

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regWriteM, regWriteW, loadE, pcSrcE, mdStartE, cntClr,
        input  fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM,
        input  mdBusy, mdDone, stallCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_sched.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sched
// Purpose  : 5-stage pipeline hazard control, forwarding and mul/div sequencer.
// Revision : 1.0  initial release
// ============================================================================
module hazard_sched #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_sched_if.slave hz
);
    localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       mdCnt_q, mdCnt_d;
    logic [CNT_W-1:0] stallCnt_q;
    logic             mdStall, mdDone, lwStall;
    logic             stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0]       fwdA, fwdB;

    always_comb begin
        fwdA = 2'b00;
        if (hz.regWriteM && hz.rdM != 5'd0 && hz.rdM == hz.rs1E)
            fwdA = 2'b10;
        else if (hz.regWriteW && hz.rdW != 5'd0 && hz.rdW == hz.rs1E)
            fwdA = 2'b01;
    end

    always_comb begin
        fwdB = 2'b00;
        if (hz.regWriteM && hz.rdM != 5'd0 && hz.rdM == hz.rs2E)
            fwdB = 2'b10;
        else if (hz.regWriteW && hz.rdW != 5'd0 && hz.rdW == hz.rs2E)
            fwdB = 2'b01;
    end

    assign lwStall = hz.loadE && (hz.rdE != 5'd0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mdCnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            mdCnt_q <= mdCnt_d;
        end
    end

    // A start seen while reset is held cannot enter BUSY, so it must not stall either.
    always_comb begin
        state_d = state_q;
        mdCnt_d = mdCnt_q;
        mdStall = 1'b0;
        mdDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.mdStartE && !rst) begin
                    mdStall = 1'b1;
                    mdCnt_d = MD_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mdCnt_q != 4'd0) begin
                    mdStall = 1'b1;
                    mdCnt_d = mdCnt_q - 4'd1;
                end else begin
                    mdDone  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mul/div hold outranks a taken branch, which outranks load-use.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (mdStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (hz.pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lwStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stallCnt_q <= '0;
        else if (hz.cntClr)
            stallCnt_q <= '0;
        else if (stallF && !(&stallCnt_q))
            stallCnt_q <= stallCnt_q + CNT_W'(1);
    end

    assign hz.fwdAE    = fwdA;
    assign hz.fwdBE    = fwdB;
    assign hz.stallF   = stallF;
    assign hz.stallD   = stallD;
    assign hz.stallE   = stallE;
    assign hz.flushD   = flushD;
    assign hz.flushE   = flushE;
    assign hz.flushM   = flushM;
    assign hz.mdBusy   = (state_q == BUSY);
    assign hz.mdDone   = mdDone;
    assign hz.stallCnt = stallCnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sched
// Purpose  : Directed self-checking bench for hazard_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_sched_if #(.CNT_W(32)) ifa ();
    hazard_sched_if #(.CNT_W(4))  ifb ();

    hazard_sched #(.MD_LAT(4), .CNT_W(32)) u_dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));
    hazard_sched #(.MD_LAT(4), .CNT_W(4))  u_dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] md_exp [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {stallF,stallD,stallE,flushD,flushE,flushM,mdBusy,mdDone}
    function automatic logic [7:0] vec_a();
        return {ifa.stallF, ifa.stallD, ifa.stallE, ifa.flushD,
                ifa.flushE, ifa.flushM, ifa.mdBusy, ifa.mdDone};
    endfunction

    task automatic clr_a();
        ifa.rs1D = 5'd0; ifa.rs2D = 5'd0; ifa.rs1E = 5'd0; ifa.rs2E = 5'd0;
        ifa.rdE  = 5'd0; ifa.rdM  = 5'd0; ifa.rdW  = 5'd0;
        ifa.regWriteM = 1'b0; ifa.regWriteW = 1'b0; ifa.loadE = 1'b0;
        ifa.pcSrcE = 1'b0; ifa.mdStartE = 1'b0; ifa.cntClr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one cycle into a mul/div start; checks the full hold sequence.
    task automatic md_seq(input string tag, input bit inj);
        for (int k = 0; k < 5; k++) begin
            if (inj && k == 2) begin
                ifa.loadE = 1'b1; ifa.rdE = 5'd3; ifa.rs1D = 5'd3;
            end
            #2;
            check($sformatf("%s_c%0d", tag, k + 1), 32'(vec_a()), 32'(md_exp[k]));
            if (inj && k == 2) begin
                ifa.loadE = 1'b0; ifa.rdE = 5'd0; ifa.rs1D = 5'd0;
            end
            tick();
        end
        ifa.mdStartE = 1'b0;
        #2;
        check({tag, "_after"}, 32'(vec_a()), 32'h0);
        check({tag, "_cnt"}, ifa.stallCnt, 32'd4);
    endtask

    initial begin
        md_exp[0] = 8'b11100100;
        md_exp[1] = 8'b11100110;
        md_exp[2] = 8'b11100110;
        md_exp[3] = 8'b11100110;
        md_exp[4] = 8'b00000011;

        rst = 1'b1;
        clr_a();
        ifb.rs1D = 5'd0; ifb.rs2D = 5'd0; ifb.rs1E = 5'd0; ifb.rs2E = 5'd0;
        ifb.rdE  = 5'd0; ifb.rdM  = 5'd0; ifb.rdW  = 5'd0;
        ifb.regWriteM = 1'b0; ifb.regWriteW = 1'b0; ifb.loadE = 1'b0;
        ifb.pcSrcE = 1'b0; ifb.mdStartE = 1'b0; ifb.cntClr = 1'b0;
        #12;
        check("rst_vec", 32'(vec_a()), 32'h0);
        check("rst_fwd", 32'({ifa.fwdAE, ifa.fwdBE}), 32'h0);
        check("rst_cnt", ifa.stallCnt, 32'd0);
        tick();
        rst = 1'b0;

        // forwarding priority
        ifa.rs1E = 5'd5; ifa.rdM = 5'd5; ifa.regWriteM = 1'b1;
        ifa.rdW = 5'd5; ifa.regWriteW = 1'b1;
        #1 check("fwdA_M", 32'(ifa.fwdAE), 32'd2);
        check("fwdB_none", 32'(ifa.fwdBE), 32'd0);
        ifa.regWriteM = 1'b0;
        #1 check("fwdA_W", 32'(ifa.fwdAE), 32'd1);
        ifa.rdM = 5'd0; ifa.rdW = 5'd0;
        #1 check("fwdA_zero", 32'(ifa.fwdAE), 32'd0);
        ifa.rs2E = 5'd7; ifa.rdW = 5'd7; ifa.regWriteW = 1'b1; ifa.regWriteM = 1'b1;
        #1 check("fwdB_W", 32'(ifa.fwdBE), 32'd1);
        check("fwdA_r0", 32'(ifa.fwdAE), 32'd0);
        clr_a();

        // load-use
        tick();
        ifa.loadE = 1'b1; ifa.rdE = 5'd3; ifa.rs2D = 5'd3;
        #1 check("lw_stall", 32'(vec_a()), 32'b11001000);
        tick();
        ifa.rdE = 5'd0;
        #1 check("lw_r0", 32'(vec_a()), 32'h0);
        check("lw_cnt", ifa.stallCnt, 32'd1);
        clr_a();
        ifa.cntClr = 1'b1;
        tick();
        ifa.cntClr = 1'b0;
        check("cnt_clr", ifa.stallCnt, 32'd0);

        // mul/div sequence with a load-use injected mid-hold
        ifa.mdStartE = 1'b1;
        md_seq("md", 1'b1);

        // branch beats load-use
        ifa.pcSrcE = 1'b1; ifa.loadE = 1'b1; ifa.rdE = 5'd3; ifa.rs2D = 5'd3;
        #1 check("br_lw", 32'(vec_a()), 32'b00011000);
        tick();
        check("br_cnt", ifa.stallCnt, 32'd4);
        clr_a();

        // reset while BUSY with counter at 2
        ifa.mdStartE = 1'b1;
        tick();
        tick();
        check("pre_rst_busy", 32'(ifa.mdBusy), 32'd1);
        rst = 1'b1;
        #1 check("rst_busy_vec", 32'(vec_a()), 32'h0);
        check("rst_busy_cnt", ifa.stallCnt, 32'd0);
        tick();
        rst = 1'b0;
        md_seq("md_restart", 1'b0);
        clr_a();

        // saturation on the narrow counter
        tick();
        ifb.loadE = 1'b1; ifb.rdE = 5'd3; ifb.rs1D = 5'd3;
        repeat (15) @(posedge clk);
        #1 check("sat_15", 32'(ifb.stallCnt), 32'd15);
        repeat (5) @(posedge clk);
        #1 check("sat_hold", 32'(ifb.stallCnt), 32'd15);
        ifb.cntClr = 1'b1;
        tick();
        check("sat_clr", 32'(ifb.stallCnt), 32'd0);
        ifb.cntClr = 1'b0;
        tick();
        check("sat_resume", 32'(ifb.stallCnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
